// File: rtl/tick_count_arbiter_pkg.sv
// Shared defaults and helpers for the tick counting arbiter.
// Other files in this block pull these in with a package import.
package tick_count_arbiter_pkg;

  localparam int unsigned N_REQ_DEFAULT = 4;
  localparam int unsigned CNT_W_DEFAULT = 8;

  // LSB position of counter idx inside the concatenated cnt_all bus.
  function automatic int unsigned cnt_slice_lsb(input int unsigned idx,
                                                input int unsigned cnt_w);
    return idx * cnt_w;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_count_arbiter_rr_arbiter.sv
// Round-robin one-hot selector: scans requests starting at ptr_i and wraps,
// granting the first set bit it finds.
module rr_arbiter
  import tick_count_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT
) (
  input  logic [N_REQ-1:0]            req_i,
  input  logic [ptr_width(N_REQ)-1:0] ptr_i,
  output logic [N_REQ-1:0]            gnt_o
);

  int   scanIdx;
  logic found;

  always_comb begin
    gnt_o   = '0;
    found   = 1'b0;
    scanIdx = 0;
    for (int off = 0; off < int'(N_REQ); off++) begin
      scanIdx = (int'(ptr_i) + off) % int'(N_REQ);
      if (!found && req_i[scanIdx]) begin
        gnt_o[scanIdx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tick_count_arbiter.sv
// Per-requester event counters sharing one incrementer, with a registered
// round-robin grant deciding which counter is bumped on each edge.
module tick_count_arbiter
  import tick_count_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_tick,
  input  logic                   clr,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ*CNT_W-1:0] cnt_all,
  output logic [N_REQ-1:0]       ovf,
  output logic [N_REQ-1:0]       lost,
  output logic                   busy
);

  localparam int unsigned PTR_W = ptr_width(N_REQ);

  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] ovf_q, ovf_d;
  logic [N_REQ-1:0] lost_q, lost_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q [N_REQ];
  logic [CNT_W-1:0] cnt_d [N_REQ];

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] rrGnt;
  logic [PTR_W-1:0] incIdx;
  logic [CNT_W-1:0] incOperand;
  logic [CNT_W:0]   incSum;

  // A bit being served this cycle is still pending until the edge; mask it so
  // it is not granted twice for one event.
  assign eligible = pending_q & ~grant_q;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_rr (
    .req_i(eligible),
    .ptr_i(ptr_q),
    .gnt_o(rrGnt)
  );

  always_comb begin
    incIdx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (grant_q[i]) incIdx = PTR_W'(i);
    end
    incOperand = cnt_q[incIdx];
    incSum     = {1'b0, incOperand} + (CNT_W + 1)'(1);
  end

  always_comb begin
    pending_d = (pending_q & ~grant_q) | req_tick;
    lost_d    = lost_q | (req_tick & pending_q & ~grant_q);
    ovf_d     = ovf_q;
    grant_d   = rrGnt;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (rrGnt[i]) ptr_d = PTR_W'((i + 1) % int'(N_REQ));
    end
    if (|grant_q) begin
      cnt_d[incIdx] = incSum[CNT_W-1:0];
      if (incSum[CNT_W]) ovf_d[incIdx] = 1'b1;
    end
    // Clear wins over everything, including ticks arriving this cycle.
    if (clr) begin
      pending_d = '0;
      lost_d    = '0;
      ovf_d     = '0;
      grant_d   = '0;
      ptr_d     = '0;
      for (int i = 0; i < int'(N_REQ); i++) cnt_d[i] = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= '0;
      grant_q   <= '0;
      ovf_q     <= '0;
      lost_q    <= '0;
      ptr_q     <= '0;
      for (int i = 0; i < int'(N_REQ); i++) cnt_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      grant_q   <= grant_d;
      ovf_q     <= ovf_d;
      lost_q    <= lost_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign grant = grant_q;
  assign ovf   = ovf_q;
  assign lost  = lost_q;
  assign busy  = |pending_q;

  for (genvar g = 0; g < int'(N_REQ); g++) begin : gen_cnt_out
    assign cnt_all[cnt_slice_lsb(g, CNT_W) +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_tick_count_arbiter.sv
// Bench for tick_count_arbiter: stimulus queues expected grants, a monitor
// pops them whenever a grant appears and checks the counter one cycle later.
module tb_tick_count_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             clr;
  logic [N-1:0]     req_tick;
  logic [N-1:0]     grant;
  logic [N*W-1:0]   cnt_all;
  logic [N-1:0]     ovf;
  logic [N-1:0]     lost;
  logic             busy;

  always #5 clk = ~clk;

  tick_count_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
    .clk(clk),
    .reset(reset),
    .req_tick(req_tick),
    .clr(clr),
    .grant(grant),
    .cnt_all(cnt_all),
    .ovf(ovf),
    .lost(lost),
    .busy(busy)
  );

  typedef struct {
    logic [N-1:0] g;
    int           idx;
    logic [W-1:0] c;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad = 0;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [W-1:0] cntOf(input int i);
    return cnt_all[i*W +: W];
  endfunction

  task automatic pushExp(input logic [N-1:0] g, input int idx, input logic [W-1:0] c);
    exp_t e;
    e.g = g;
    e.idx = idx;
    e.c = c;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v);
    req_tick = v;
    @(posedge clk);
    #1;
    req_tick = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clearPulse();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Monitor: a grant seen in one cycle is checked against the queue, and the
  // granted counter is checked on the following cycle.
  logic         pendChk = 1'b0;
  int           chkIdx = 0;
  logic [W-1:0] chkCnt = '0;
  exp_t         monE;

  always @(negedge clk) begin
    if (pendChk) begin
      checkOutput($sformatf("cnt%0d after grant", chkIdx), 32'(cntOf(chkIdx)), 32'(chkCnt));
      pendChk = 1'b0;
    end
    if (reset === 1'b1 && grant !== '0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected grant", 32'(grant), 32'h0);
      end else begin
        monE = expQ.pop_front();
        checkOutput("grant order", 32'(grant), 32'(monE.g));
        chkIdx  = monE.idx;
        chkCnt  = monE.c;
        pendChk = 1'b1;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int guard;
    reset    = 1'b0;
    clr      = 1'b0;
    req_tick = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset grant", 32'(grant), 32'h0);
    checkOutput("reset cnt_all", cnt_all, 32'h0);
    checkOutput("reset ovf", 32'(ovf), 32'h0);
    checkOutput("reset lost", 32'(lost), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single tick on requester 2.
    pushExp(4'b0100, 2, 8'd1);
    applyStimulus(4'b0100);
    checkOutput("busy after tick", 32'(busy), 32'h1);
    idle(4);
    checkOutput("single cnt2", 32'(cntOf(2)), 32'h1);
    checkOutput("single others", 32'({cntOf(3), cntOf(1), cntOf(0)}), 32'h0);
    checkOutput("single busy idle", 32'(busy), 32'h0);

    // All four at once: round-robin from pointer 0.
    clearPulse();
    checkOutput("clr cnt2", 32'(cntOf(2)), 32'h0);
    pushExp(4'b0001, 0, 8'd1);
    pushExp(4'b0010, 1, 8'd1);
    pushExp(4'b0100, 2, 8'd1);
    pushExp(4'b1000, 3, 8'd1);
    applyStimulus(4'b1111);
    idle(6);
    checkOutput("burst cnt_all", cnt_all, 32'h01010101);
    checkOutput("burst lost", 32'(lost), 32'h0);
    checkOutput("burst busy", 32'(busy), 32'h0);

    // Requester 0 held for three edges: middle tick is lost, last one merges.
    clearPulse();
    pushExp(4'b0001, 0, 8'd1);
    pushExp(4'b0001, 0, 8'd2);
    req_tick = 4'b0001;
    idle(3);
    req_tick = '0;
    idle(5);
    checkOutput("held cnt0", 32'(cntOf(0)), 32'h2);
    checkOutput("held lost", 32'(lost), 32'h1);
    checkOutput("held busy", 32'(busy), 32'h0);

    // 256 ticks on requester 1 wrap the counter back to 0.
    clearPulse();
    for (int k = 1; k <= 256; k++) begin
      pushExp(4'b0010, 1, 8'(k));
      applyStimulus(4'b0010);
      idle(2);
    end
    idle(2);
    checkOutput("wrap cnt1", 32'(cntOf(1)), 32'h0);
    checkOutput("wrap ovf", 32'(ovf), 32'h2);
    checkOutput("wrap lost", 32'(lost), 32'h0);

    // Clear while busy, with ticks arriving in the clear cycle.
    pushExp(4'b0001, 0, 8'd1);
    applyStimulus(4'b0001);
    idle(3);
    checkOutput("preclr cnt0", 32'(cntOf(0)), 32'h1);
    req_tick = 4'b1111;
    @(posedge clk);
    #1;
    checkOutput("preclr busy", 32'(busy), 32'h1);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    req_tick = '0;
    checkOutput("clr grant", 32'(grant), 32'h0);
    checkOutput("clr busy", 32'(busy), 32'h0);
    checkOutput("clr cnt_all", cnt_all, 32'h0);
    checkOutput("clr ovf", 32'(ovf), 32'h0);
    checkOutput("clr lost", 32'(lost), 32'h0);
    idle(3);
    checkOutput("clr no increment", cnt_all, 32'h0);

    // Asynchronous reset in the middle of a grant.
    pushExp(4'b0001, 0, 8'd1);
    applyStimulus(4'b0001);
    idle(3);
    checkOutput("prerst cnt0", 32'(cntOf(0)), 32'h1);
    applyStimulus(4'b1111);
    @(posedge clk);
    #1;
    checkOutput("prerst grant", 32'(grant), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst grant", 32'(grant), 32'h0);
    checkOutput("rst cnt_all", cnt_all, 32'h0);
    checkOutput("rst busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    pushExp(4'b0001, 0, 8'd1);
    pushExp(4'b1000, 3, 8'd1);
    applyStimulus(4'b1001);
    idle(5);
    checkOutput("postrst cnt3", 32'(cntOf(3)), 32'h1);
    checkOutput("postrst cnt0", 32'(cntOf(0)), 32'h1);
    checkOutput("postrst busy", 32'(busy), 32'h0);

    guard = 0;
    while (expQ.size() != 0 && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("queue drained", 32'(expQ.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_count_arbiter.md
TICK_COUNT_ARBITER -- requirements
Module: tick_count_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of tick requesters and counters.
REQ-002 Parameter CNT_W, default 8: width of each event counter.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (reset=0 resets all state immediately).
REQ-005 req_tick  input  N_REQ  per-requester event pulses; each high bit in a sampled cycle is one event.
REQ-006 clr  input  1  synchronous clear of all counters and status.
REQ-007 grant  output  N_REQ  registered one-hot grant, indicating which counter is incremented at the next edge; all-zero when idle.
REQ-008 cnt_all  output  N_REQ*CNT_W  concatenated counters; counter i occupies bits [i*CNT_W +: CNT_W].
REQ-009 ovf  output  N_REQ  sticky flags: counter i wrapped from max to 0.
REQ-010 lost  output  N_REQ  sticky flags: an event on i was dropped because pending[i] was already set.
REQ-011 busy  output  1  high when any pending bit is set.

Function
REQ-012 The block SHALL keep one pending bit per requester; req_tick[i]=1 sets pending[i] at the next edge.
REQ-013 The arbiter SHALL grant at most one requester per cycle, chosen from the registered pending vector.
REQ-014 Grant order SHALL be round-robin: search starts at (last_granted+1) mod N_REQ and wraps; the pointer starts at 0 after reset/clr.
REQ-015 The granted counter SHALL increment by 1 at the edge ending the grant cycle, through a single shared CNT_W-bit incrementer; the grant SHALL also clear the requester's pending bit at that edge.
REQ-016 Latency SHALL be: tick sampled at edge t sets pending; grant is asserted during cycle t+1 at the earliest; the count is visible at edge t+2.
REQ-017 If req_tick[i] coincides with grant[i], pending[i] SHALL remain set (a new event is accepted, and no loss occurs).
REQ-018 If req_tick[i]=1 while pending[i]=1 and grant[i]=0, the event SHALL be dropped and lost[i] set.
REQ-019 Counter arithmetic SHALL be modulo 2^CNT_W; an increment from all-ones SHALL produce 0 and set ovf[i].
REQ-020 clr SHALL take priority over all other activity: at the next edge, counters, pending, ovf, lost and the pointer go to 0; grant is 0 in the following cycle; ticks in the clr cycle are discarded.
REQ-021 busy SHALL equal the OR of the pending bits (combinational from registers).
REQ-022 With no pending bits, grant SHALL be all-zero and the counters SHALL hold.

Reset
REQ-023 On reset=0 (asynchronous), the block SHALL set all counters, pending, ovf, lost, grant, and the pointer to 0; busy SHALL read 0.
REQ-024 Reset asserted mid-grant SHALL abort the increment; after release, the first edge SHALL behave as the post-clr state.
REQ-025 There SHALL be no reset synchronizer inside the block; release timing is the integrator's responsibility.

Structure
REQ-026 N_REQ and CNT_W defaults, plus the cnt_all slice width macro, SHALL live in the shared project include/package file.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (inputs: req vector, pointer; output: one-hot grant).
REQ-028 Counters, pending, status and the incrementer SHALL stay in tick_count_arbiter; there SHALL be exactly one adder instance.

Verification
REQ-029 Single tick on req_tick[2] after reset -> grant=0100 one cycle later, and cnt2=1 the cycle after; other counts 0, busy back to 0.
REQ-030 req_tick=1111 for one cycle -> grants 0001,0010,0100,1000 on consecutive cycles; all counts=1; lost=0000.
REQ-031 req_tick[0] held high for 3 cycles -> cnt0=2 or 3 per REQ-017/018 timing, and lost[0] set exactly when a tick hits pending without grant; the bench checks against a model.
REQ-032 Preload cnt1 to 255 with 255 ticks, then one more tick -> cnt1=0, ovf[1]=1, and other ovf bits 0.
REQ-033 clr together with req_tick=1111 while busy -> next cycle all counts, pending, ovf, lost=0, grant=0000, and no increment.
REQ-034 reset=0 asserted asynchronously mid-stream (between edges) -> outputs go to 0 immediately; after release, a single tick on req_tick[3] -> cnt3=1 with grant order restarting from pointer 0.
